// File: rtl/csr_access_initiator.sv
// CSR access initiator: serializes CSRRW/CSRRS/CSRRC as a read-modify-write
// against the per-core CSR data store and returns the old value as writeback.
module csr_access_initiator #(
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44,
    parameter int DATA_BITS     = 32
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [UUID_BITS-1:0]     req_uuid,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [CSR_ADDR_BITS-1:0] req_addr,
    input  logic [1:0]               req_op,
    input  logic [DATA_BITS-1:0]     req_src,
    input  logic                     req_src_zero,
    input  logic                     req_rd_zero,

    output logic                     read_enable,
    output logic [UUID_BITS-1:0]     read_uuid,
    output logic [CSR_ADDR_BITS-1:0] read_addr,
    output logic [NW_BITS-1:0]       read_wid,
    input  logic [DATA_BITS-1:0]     read_data,

    output logic                     write_enable,
    output logic [UUID_BITS-1:0]     write_uuid,
    output logic [CSR_ADDR_BITS-1:0] write_addr,
    output logic [NW_BITS-1:0]       write_wid,
    output logic [DATA_BITS-1:0]     write_data,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [UUID_BITS-1:0]     rsp_uuid,
    output logic [NW_BITS-1:0]       rsp_wid,
    output logic [DATA_BITS-1:0]     rsp_data,

    output logic                     busy,
    output logic [31:0]              num_reads,
    output logic [31:0]              num_writes
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t                   state;
    state_t                   state_next;

    logic [UUID_BITS-1:0]     lat_uuid;
    logic [NW_BITS-1:0]       lat_wid;
    logic [CSR_ADDR_BITS-1:0] lat_addr;
    logic [1:0]               lat_op;
    logic [DATA_BITS-1:0]     lat_src;
    logic                     lat_src_zero;
    logic                     lat_rd_zero;
    logic [DATA_BITS-1:0]     old_val;
    logic [DATA_BITS-1:0]     new_val;

    // Decoded view of the latched request; op 00 behaves as RW
    logic                     op_is_rw;
    logic                     read_needed;
    logic                     do_write;
    logic [DATA_BITS-1:0]     old_now;
    logic [DATA_BITS-1:0]     new_now;

    assign op_is_rw    = (lat_op != OP_RS) && (lat_op != OP_RC);
    assign read_needed = ~(op_is_rw && lat_rd_zero);
    assign do_write    = op_is_rw || ~lat_src_zero;
    assign old_now     = (state == READ && read_needed) ? read_data : '0;

    // New CSR value from the old value and the source operand
    always_comb begin
        new_now = lat_src;
        case (lat_op)
            OP_RS:   new_now = old_now | lat_src;
            OP_RC:   new_now = old_now & ~lat_src;
            default: new_now = lat_src;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered
                req_ready = reset;
                if (req_valid) state_next = READ;
            end
            READ: begin
                read_enable = read_needed;
                state_next  = do_write ? WRITE : RESP;
            end
            WRITE: begin
                write_enable = 1'b1;
                state_next   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture request fields on accept and the read/compute results in READ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_uuid     <= '0;
            lat_wid      <= '0;
            lat_addr     <= '0;
            lat_op       <= '0;
            lat_src      <= '0;
            lat_src_zero <= 1'b0;
            lat_rd_zero  <= 1'b0;
            old_val      <= '0;
            new_val      <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_uuid     <= req_uuid;
                lat_wid      <= req_wid;
                lat_addr     <= req_addr;
                lat_op       <= req_op;
                lat_src      <= req_src;
                lat_src_zero <= req_src_zero;
                lat_rd_zero  <= req_rd_zero;
            end
            if (state == READ) begin
                old_val <= old_now;
                new_val <= new_now;
            end
        end
    end

    // Access counters, free-running with natural wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_reads  <= '0;
            num_writes <= '0;
        end else begin
            if (read_enable)  num_reads  <= num_reads + 32'd1;
            if (write_enable) num_writes <= num_writes + 32'd1;
        end
    end

    assign read_uuid  = lat_uuid;
    assign read_addr  = lat_addr;
    assign read_wid   = lat_wid;

    assign write_uuid = lat_uuid;
    assign write_addr = lat_addr;
    assign write_wid  = lat_wid;
    assign write_data = new_val;

    assign rsp_uuid   = lat_uuid;
    assign rsp_wid    = lat_wid;
    assign rsp_data   = old_val;

    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_csr_access_initiator.sv
// Directed bench for csr_access_initiator with hand-computed expectations.
module tb_csr_access_initiator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [43:0] req_uuid;
    logic [1:0]  req_wid;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic        req_rd_zero;
    logic        read_enable;
    logic [43:0] read_uuid;
    logic [11:0] read_addr;
    logic [1:0]  read_wid;
    logic [31:0] read_data;
    logic        write_enable;
    logic [43:0] write_uuid;
    logic [11:0] write_addr;
    logic [1:0]  write_wid;
    logic [31:0] write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [43:0] rsp_uuid;
    logic [1:0]  rsp_wid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [31:0] num_reads;
    logic [31:0] num_writes;

    int total = 0;
    int bad   = 0;

    csr_access_initiator dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
        .req_wid(req_wid), .req_addr(req_addr), .req_op(req_op),
        .req_src(req_src), .req_src_zero(req_src_zero), .req_rd_zero(req_rd_zero),
        .read_enable(read_enable), .read_uuid(read_uuid), .read_addr(read_addr),
        .read_wid(read_wid), .read_data(read_data),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_addr(write_addr),
        .write_wid(write_wid), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_data(rsp_data),
        .busy(busy), .num_reads(num_reads), .num_writes(num_writes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction; exp_rd/exp_wr say whether a read/write pulse must appear
    task automatic run_req(input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] src, input logic sz, input logic rz,
                           input logic [31:0] store, input int hold,
                           input logic exp_rd, input logic exp_wr,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rsp,
                           input logic [43:0] uid);
        logic [31:0] r0;
        logic [31:0] w0;
        @(negedge clk);
        check("idle_ready", {63'd0, req_ready}, 64'd1);
        r0           = num_reads;
        w0           = num_writes;
        req_valid    = 1'b1;
        req_uuid     = uid;
        req_wid      = 2'd2;
        req_addr     = addr;
        req_op       = op;
        req_src      = src;
        req_src_zero = sz;
        req_rd_zero  = rz;
        read_data    = store;
        @(posedge clk);
        #1;
        // Changes while busy must be ignored
        req_valid = 1'b0;
        req_addr  = 12'hFFF;
        req_src   = 32'hFFFF_FFFF;
        req_op    = 2'b11;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check("rd_en", {63'd0, read_enable}, {63'd0, exp_rd});
        check("rd_busy_wr0", {62'd0, busy, write_enable}, 64'd2);
        if (exp_rd) check("rd_addr", {52'd0, read_addr}, {52'd0, addr});
        if (exp_wr) begin
            @(negedge clk);
            check("wr_en", {62'd0, write_enable, read_enable}, 64'd2);
            check("wr_data", {32'd0, write_data}, {32'd0, exp_wd});
            check("wr_addr", {50'd0, write_wid, write_addr}, {50'd0, 2'd2, addr});
        end
        @(negedge clk);
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_data", {32'd0, rsp_data}, {32'd0, exp_rsp});
        check("rsp_uuid", {20'd0, rsp_uuid}, {20'd0, uid});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_state", {61'd0, rsp_valid, req_ready, write_enable}, 64'd4);
            check("hold_data", {32'd0, rsp_data}, {32'd0, exp_rsp});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("back_idle", {62'd0, busy, req_ready}, 64'd1);
        check("num_reads", {32'd0, num_reads}, {32'd0, r0 + {31'd0, exp_rd}});
        check("num_writes", {32'd0, num_writes}, {32'd0, w0 + {31'd0, exp_wr}});
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_uuid     = '0;
        req_wid      = '0;
        req_addr     = '0;
        req_op       = '0;
        req_src      = '0;
        req_src_zero = 1'b0;
        req_rd_zero  = 1'b0;
        read_data    = '0;
        rsp_ready    = 1'b1;

        #12;
        check("rst_ready_busy", {62'd0, req_ready, busy}, 64'd0);
        check("rst_strobes", {61'd0, read_enable, write_enable, rsp_valid}, 64'd0);
        check("rst_counters", {num_reads, num_writes}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // RW: old 0x11, write 0xA5
        run_req(12'h300, 2'b01, 32'hA5, 1'b0, 1'b0, 32'h11, 0, 1'b1, 1'b1, 32'hA5, 32'h11, 44'h101);
        // RS: 0xF0 | 0x0F
        run_req(12'h301, 2'b10, 32'h0F, 1'b0, 1'b0, 32'hF0, 0, 1'b1, 1'b1, 32'hFF, 32'hF0, 44'h102);
        // RC: 0xFF & ~0x0F
        run_req(12'h302, 2'b11, 32'h0F, 1'b0, 1'b0, 32'hFF, 0, 1'b1, 1'b1, 32'hF0, 32'hFF, 44'h103);
        // RS with zero source: no write
        run_req(12'h303, 2'b10, 32'h0, 1'b1, 1'b0, 32'h1234, 0, 1'b1, 1'b0, 32'h0, 32'h1234, 44'h104);
        // RW with rd==x0: no read, rsp 0
        run_req(12'h304, 2'b01, 32'h55, 1'b0, 1'b1, 32'hDEAD, 0, 1'b0, 1'b1, 32'h55, 32'h0, 44'h105);
        // RW with 5 cycles of response backpressure
        run_req(12'h305, 2'b01, 32'h7, 1'b0, 1'b0, 32'h3, 5, 1'b1, 1'b1, 32'h7, 32'h3, 44'h106);
        // Back-to-back; op 00 behaves as RW
        run_req(12'h306, 2'b00, 32'h9, 1'b0, 1'b0, 32'h8, 0, 1'b1, 1'b1, 32'h9, 32'h8, 44'h107);
        // RC with zero source: no write
        run_req(12'h307, 2'b11, 32'h0, 1'b1, 1'b0, 32'h77, 0, 1'b1, 1'b0, 32'h0, 32'h77, 44'h108);
        check("final_counts", {num_reads, num_writes}, {32'd7, 32'd6});

        // Reset asserted in the middle of WRITE
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = 12'h340;
        req_op       = 2'b01;
        req_src      = 32'hABCD;
        req_src_zero = 1'b0;
        req_rd_zero  = 1'b0;
        read_data    = 32'h1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_write", {62'd0, write_enable, busy}, 64'd3);
        #1;
        reset = 1'b0;
        #1;
        check("async_drop", {62'd0, write_enable, busy}, 64'd0);
        check("async_counters", {num_reads, num_writes}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {62'd0, busy, req_ready}, 64'd1);
        check("post_rst_counters", {num_reads, num_writes}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
